sum_seg_display: RTL and testbench
==================================

# sum_seg_display

Downstream display stage for the 8-bit registered adder result. Accepts a sum value with a one-cycle load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then scans hundreds, tens, ones and a blank gap on the single 7-segment output, each digit held for a programmable dwell time. All outputs are registered. Sequential behaviour: FSM, conversion step counter, dwell counter, pending-load buffer.

## Interface
- DWELL_CYCLES, default 1000000: clock cycles each digit phase is held; legal range 2..2^24-1.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-low.
- sum_in  input  8  unsigned value to display, 0..255.
- sum_valid  input  1  load strobe; sum_in sampled on the same edge.
- seg_out  output  8  {dp,g,f,e,d,c,b,a}, active high; reset 8'h00.
- busy  output  1  high while a conversion runs; reset 0.

## Operation
- States: IDLE (after reset, seg_out 8'h00), CONVERT, SHOW.
- IDLE/SHOW + sum_valid: capture sum_in, clear BCD scratch, enter CONVERT, busy=1.
- CONVERT: 8 steps; each step adds 3 to any BCD nibble >=5, then shifts {bcd,bin} left 1. Scratch 12 bits BCD + 8 bits binary; no overflow possible for 0..255.
- After step 8: latch hundreds/tens/ones digit registers, busy=0, enter SHOW with phase=HUND, dwell counter=0.
- SHOW phases in order HUND, TENS, ONES, GAP, wrapping GAP->HUND; each phase lasts exactly DWELL_CYCLES cycles.
- Encodings: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; GAP=00. dp (bit 7) set only in ONES phase, marking end of number.
- sum_valid during CONVERT: value stored in pending register (last strobe wins), not dropped. On completion, if pending, start a new conversion immediately (busy stays 1, no SHOW entry); the completed digits are discarded.
- seg_out holds its last value throughout CONVERT.
- sum_valid in SHOW restarts conversion; scan restarts at HUND afterwards.
- rst_n low on any edge, including mid-conversion: IDLE, seg_out 00, busy 0, pending cleared, counters 0.

## Timing
- sum_valid sampled at edge E0 (state IDLE/SHOW): busy=1 after E0; steps at E1..E8; busy=0 and digit registers valid after E8.
- HUND digit on seg_out after E9; TENS after E9+DWELL_CYCLES; ONES after E9+2*DWELL_CYCLES; GAP after E9+3*DWELL_CYCLES; HUND again after E9+4*DWELL_CYCLES.
- Load-to-first-digit latency: 9 cycles. Back-to-back: pending start at E8, busy continuous, next digits after E16.

## Configuration
- LEADING_ZERO_BLANK_EN defined: HUND phase shows 00 when hundreds=0; TENS phase shows 00 when hundreds=0 and tens=0; ONES always shown; phase durations unchanged.
- Not defined: all three digits always displayed, including leading zeros.

## Test plan
- Reset: hold rst_n=0 3 cycles -> seg_out=00, busy=0; with no strobe seg_out stays 00 for 100 cycles.
- DWELL_CYCLES=4, macro off, sum_in=27 strobe -> busy 8 cycles; seg_out 3F, 5B, 87, 00 each 4 cycles, then repeats.
- Same with LEADING_ZERO_BLANK_EN, sum_in=5 -> 00, 00, ED, 00; sum_in=30 -> 00, 4F, BF, 00.
- sum_in=255 -> 06, 6D, ED, 00; sum_in=0 (macro off) -> 3F, 3F, BF, 00.
- Strobe 12 then strobes 200 and 143 during CONVERT -> busy continuous 16 cycles; display shows 06, 66, CF, 00 (143); 12 and 200 never displayed.
- rst_n=0 at step 4 of conversion of 99 -> next cycle seg_out=00, busy=0; no digits appear afterwards without a new strobe.

Source files
------------

// File: rtl/sum_seg_display.sv
// sum_seg_display: 8-bit value -> 3 BCD digits (sequential double-dabble),
// scanned HUND, TENS, ONES, GAP on one 7-segment output, DWELL_CYCLES per phase.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sum_seg_display #(
  parameter int unsigned DWELL_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sum_in,
  input  logic       sum_valid,
  output logic [7:0] seg_out,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW} state_e;
  typedef enum logic [1:0] {P_HUND, P_TENS, P_ONES, P_GAP} phase_e;

  localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [2:0]  step_q, step_d;
  logic [23:0] dwell_q, dwell_d;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  bin_q, bin_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic        pend_q, pend_d;
  logic [7:0]  pval_q, pval_d;
  logic [7:0]  seg_q, seg_d;
  logic        busy_q, busy_d;

  logic [11:0] bcd_adj, bcd_step;
  logic [7:0]  bin_step;
  logic [7:0]  seg_enc;
  logic        blank_hund, blank_tens;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_step, bin_step} = {bcd_adj[10:0], bin_q, 1'b0};
  end

  // Segment pattern for the current scan phase; dp marks the ones digit.
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hund = (hund_q == 4'd0);
  assign blank_tens = (hund_q == 4'd0) && (tens_q == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    seg_enc = 8'h00;
    case (phase_q)
      P_HUND: seg_enc = blank_hund ? 8'h00 : seg7(hund_q);
      P_TENS: seg_enc = blank_tens ? 8'h00 : seg7(tens_q);
      P_ONES: seg_enc = seg7(ones_q) | 8'h80;
      default: seg_enc = 8'h00;
    endcase
  end

  // Next-state: load/convert/scan control, pending-load handling.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    seg_d   = seg_q;
    busy_d  = busy_q;
    case (state_q)
      S_CONVERT: begin
        bcd_d  = bcd_step;
        bin_d  = bin_step;
        step_d = step_q + 3'd1;
        if (sum_valid) begin
          pend_d = 1'b1;
          pval_d = sum_in;
        end
        if (step_q == 3'd7) begin
          if (sum_valid || pend_q) begin
            // Newer value waiting: discard these digits, convert again.
            bin_d  = sum_valid ? sum_in : pval_q;
            bcd_d  = '0;
            step_d = '0;
            pend_d = 1'b0;
          end else begin
            hund_d  = bcd_step[11:8];
            tens_d  = bcd_step[7:4];
            ones_d  = bcd_step[3:0];
            busy_d  = 1'b0;
            state_d = S_SHOW;
            phase_d = P_HUND;
            dwell_d = '0;
          end
        end
      end
      default: begin
        if (sum_valid) begin
          bin_d   = sum_in;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = S_CONVERT;
        end else if (state_q == S_SHOW) begin
          seg_d = seg_enc;
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            phase_d = phase_e'(phase_q + 2'd1);
          end else begin
            dwell_d = dwell_q + 24'd1;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= P_HUND;
      step_q  <= '0;
      dwell_q <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      seg_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_out = seg_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sum_seg_display.sv
// Scoreboard bench for sum_seg_display with DWELL_CYCLES=4; honours LEADING_ZERO_BLANK_EN.
module tb_sum_seg_display;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sum_in = '0;
  logic       sum_valid = 1'b0;
  logic [7:0] seg_out;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  sum_seg_display #(.DWELL_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
    .seg_out(seg_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int d);
    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return tbl[d];
  endfunction

  // Expected scan for value v: two full rounds, one entry per cycle.
  task automatic push_exp(input int v);
    int h, t, o;
    logic [7:0] ph [4];
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    ph[0] = enc(h);
    ph[1] = enc(t);
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) ph[0] = 8'h00;
    if (h == 0 && t == 0) ph[1] = 8'h00;
`endif
    ph[2] = enc(o) | 8'h80;
    ph[3] = 8'h00;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        for (int c = 0; c < D; c++) exp_q.push_back(ph[p]);
  endtask

  task automatic wait_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp_n);
  endtask

  // Called once busy has dropped (after the final conversion edge).
  task automatic drain(input string tag);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      chk(tag, seg_out, exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic run(input int v);
    sum_in = 8'(v);
    sum_valid = 1'b1;
    push_exp(v);
    @(negedge clk);
    sum_valid = 1'b0;
    wait_busy("busy_len", 8);
    drain("scan");
  endtask

  initial begin
    // Reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", {busy, seg_out}, 9'h000);
    end

    run(27);
    run(5);
    run(30);
    run(255);
    run(0);

    // Strobes during conversion: only the last one is displayed.
    sum_in = 8'd12; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    chk("b2b_busy0", busy, 1'b1);
    @(negedge clk);
    sum_in = 8'd200; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    @(negedge clk);
    sum_in = 8'd143; sum_valid = 1'b1;
    push_exp(143);
    @(negedge clk);
    sum_valid = 1'b0;
    wait_busy("b2b_busy", 12);
    drain("b2b_scan");

    // Reset mid-conversion.
    sum_in = 8'd99; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_seg", seg_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst", {busy, seg_out}, 9'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
